// File: rtl/cond_exec_ctrl.sv
// Execute-stage condition evaluation, NZCV ownership and
// wrong-path squash sequencing after a taken branch.
module cond_exec_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_e,
  input  logic             stall_e,
  input  logic [3:0]       cond_e,
  input  logic [1:0]       flagw_e,
  input  logic [3:0]       alu_flags,
  input  logic             regw_e,
  input  logic             memw_e,
  input  logic             pcs_e,
  output logic             cond_ex,
  output logic             regwrite_g,
  output logic             memwrite_g,
  output logic             pcsrc,
  output logic             flush_d,
  output logic             flush_e,
  output logic [3:0]       flags_q,
  output logic             busy,
  output logic [CNT_W-1:0] squash_cnt
);

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_t;

  localparam bit LP_HAS_FLUSH = (FLUSH_CYCLES > 0);
  localparam logic [2:0] LP_CNT_INIT =
    LP_HAS_FLUSH ? 3'(FLUSH_CYCLES - 1) : 3'd0;
  localparam logic [CNT_W-1:0] LP_SQ_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt_nxt;
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_sq;

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_condpass;
  logic w_live;
  logic w_cond_ex;
  logic w_pcsrc;
  logic w_in_flush;
  logic w_sq_evt;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_condpass = 1'b0;
    unique case (cond_e)
      4'b0000: w_condpass = w_z;
      4'b0001: w_condpass = ~w_z;
      4'b0010: w_condpass = w_c;
      4'b0011: w_condpass = ~w_c;
      4'b0100: w_condpass = w_n;
      4'b0101: w_condpass = ~w_n;
      4'b0110: w_condpass = w_v;
      4'b0111: w_condpass = ~w_v;
      4'b1000: w_condpass = w_c & ~w_z;
      4'b1001: w_condpass = ~(w_c & ~w_z);
      4'b1010: w_condpass = (w_n == w_v);
      4'b1011: w_condpass = (w_n != w_v);
      4'b1100: w_condpass = ~w_z & (w_n == w_v);
      4'b1101: w_condpass = ~(~w_z & (w_n == w_v));
      4'b1110: w_condpass = 1'b1;
      4'b1111: w_condpass = 1'b0;
    endcase
  end

  assign w_in_flush = (r_state == ST_FLUSH);
  assign w_live = valid_e & ~stall_e
                & ~w_in_flush & ~reset;
  assign w_cond_ex = w_live & w_condpass;
  assign w_pcsrc   = w_cond_ex & pcs_e;

  // Wrong-path slots and failed conditions both count as squashed
  assign w_sq_evt = valid_e & ~stall_e
                  & (w_in_flush | ~w_condpass);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_RUN: begin
        if (w_pcsrc && LP_HAS_FLUSH) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = LP_CNT_INIT;
        end
      end
      ST_FLUSH: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (w_cond_ex) begin
      if (flagw_e[1]) begin
        r_flags[3:2] <= alu_flags[3:2];
      end
      if (flagw_e[0]) begin
        r_flags[1:0] <= alu_flags[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sq <= '0;
    end else if (w_sq_evt && r_sq != LP_SQ_MAX) begin
      r_sq <= r_sq + CNT_W'(1);
    end
  end

  assign cond_ex    = w_cond_ex;
  assign regwrite_g = w_cond_ex & regw_e;
  assign memwrite_g = w_cond_ex & memw_e;
  assign pcsrc      = w_pcsrc;
  assign flush_d    = w_pcsrc;
  assign flush_e    = w_pcsrc;
  assign flags_q    = r_flags;
  assign busy       = w_in_flush & ~reset;
  assign squash_cnt = r_sq;

endmodule
